clk_activity_led_monitor: RTL and testbench

Parametrised successor to the kernel-clock LED visualiser. It runs a prescaled free-running counter in the monitored clock domain and drives NUM_LEDS board LEDs in one of four display modes: binary MSBs, bouncing scan, PWM breathing, or solid. All logic is synchronous to the single monitored clock, with no ripple clocking. It sits in the top level next to the system instance, clocked by kernel_clk, and drives fpga_led_output.

---
 rtl/clk_activity_led_monitor.sv | 108 ++++++++++
 tb/tb_clk_activity_led_monitor.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_activity_led_monitor.sv
// clk_activity_led_monitor: prescaled activity counter driving board LEDs
// as binary MSBs, a bouncing scan, a PWM breathing ramp or solid on.
module clk_activity_led_monitor #(
  parameter int CNT_WIDTH      = 30,
  parameter int NUM_LEDS       = 4,
  parameter int PRESCALE       = 1,
  parameter int PWM_BITS       = 8,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  output logic [NUM_LEDS-1:0]  led_out,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 step_pulse
);

  typedef enum logic [1:0] {
    BINARY  = 2'd0,
    SCAN    = 2'd1,
    BREATHE = 2'd2,
    SOLID   = 2'd3
  } mode_e;

  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LOW = CNT_WIDTH - NUM_LEDS;
  localparam int TRN = (NUM_LEDS > 1) ? NUM_LEDS - 2 : 0;

  localparam logic [PW-1:0]       PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [SW-1:0]       POS_TRN = SW'(TRN);
  localparam logic [SW-1:0]       POS_ONE = SW'(1);
  localparam logic [NUM_LEDS-1:0] OFF     = {NUM_LEDS{LED_ACTIVE_LOW}};

  logic [PW-1:0]       pre_cnt;
  logic [SW-1:0]       pos;
  logic                dir_down;
  mode_e               mode_q;
  logic                tick;
  logic                step_evt;
  logic [NUM_LEDS-1:0] pattern;
  logic [PWM_BITS-1:0] f;
  logic [PWM_BITS-1:0] duty;

  assign tick     = enable && (pre_cnt == PRE_MAX);
  assign step_evt = tick && (&count[LOW-1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      count   <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      count   <= count + 1'b1;
    end else if (enable) begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Mode changes while running wait for a step boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_pulse <= 1'b0;
      mode_q     <= BINARY;
    end else begin
      step_pulse <= step_evt;
      if (step_evt || !enable) begin
        mode_q <= mode_e'(mode);
      end
    end
  end

  // Direction turns on arrival so each end LED shows for one step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos      <= '0;
      dir_down <= 1'b0;
    end else if (step_evt && mode_q == SCAN && NUM_LEDS > 1) begin
      if (!dir_down) begin
        pos <= pos + 1'b1;
        if (pos == POS_TRN) dir_down <= 1'b1;
      end else begin
        pos <= pos - 1'b1;
        if (pos == POS_ONE) dir_down <= 1'b0;
      end
    end
  end

  always_comb begin
    pattern = '0;
    f       = count[CNT_WIDTH-1 -: PWM_BITS];
    duty    = {f[PWM_BITS-1] ? ~f[PWM_BITS-2:0]
                             :  f[PWM_BITS-2:0], 1'b1};
    unique case (mode_q)
      BINARY:  pattern = count[CNT_WIDTH-1 -: NUM_LEDS];
      SCAN:    pattern = NUM_LEDS'(1) << pos;
      BREATHE: pattern = {NUM_LEDS{count[PWM_BITS-1:0] < duty}};
      SOLID:   pattern = '1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) led_out <= OFF;
    else          led_out <= pattern ^ OFF;
  end

endmodule

// File: tb/tb_clk_activity_led_monitor.sv
// tb_clk_activity_led_monitor: scoreboard bench for the LED activity monitor
// at CNT_WIDTH=8, NUM_LEDS=4, PRESCALE=2, PWM_BITS=3, active-low LEDs.
module tb_clk_activity_led_monitor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] led_out;
  logic [7:0] count;
  logic       step_pulse;

  int checks   = 0;
  int failures = 0;
  int n_pulse  = 0;

  typedef struct packed {
    logic [3:0] led;
    logic [7:0] cnt;
    logic       step;
  } obs_t;

  obs_t       exp_q[$];
  logic [3:0] led_q[$];

  // reference model state
  logic       m_pre;
  logic [7:0] m_cnt;
  int         m_phase;
  logic [1:0] m_mode;
  logic [3:0] m_led;
  logic       m_step;

  always #5 clk = ~clk;

  clk_activity_led_monitor #(
    .CNT_WIDTH(8),
    .NUM_LEDS(4),
    .PRESCALE(2),
    .PWM_BITS(3),
    .LED_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .mode(mode),
    .led_out(led_out),
    .count(count),
    .step_pulse(step_pulse)
  );

  function automatic logic [3:0] model_pattern();
    logic [2:0] f;
    logic [2:0] duty;
    int p;
    case (m_mode)
      2'd0: return m_cnt[7:4];
      2'd1: begin
        p = (m_phase < 4) ? m_phase : 6 - m_phase;
        return 4'(1 << p);
      end
      2'd2: begin
        f = m_cnt[7:5];
        duty = f[2] ? {~f[1:0], 1'b1} : {f[1:0], 1'b1};
        return (m_cnt[2:0] < duty) ? 4'hF : 4'h0;
      end
      default: return 4'hF;
    endcase
  endfunction

  task automatic model_reset();
    m_pre = 1'b0;
    m_cnt = 8'd0;
    m_phase = 0;
    m_mode = 2'd0;
    m_led = 4'hF;
    m_step = 1'b0;
    exp_q.delete();
  endtask

  task automatic cyc(input logic en, input logic [1:0] md);
    logic tick;
    logic evt;
    logic [3:0] n_led;
    obs_t e;
    enable = en;
    mode = md;
    tick = en && m_pre;
    evt = tick && (m_cnt[3:0] == 4'hF);
    n_led = model_pattern() ^ 4'hF;
    if (evt && m_mode == 2'd1) m_phase = (m_phase + 1) % 6;
    if (evt || !en) m_mode = md;
    if (tick) begin
      m_pre = 1'b0;
      m_cnt = m_cnt + 8'd1;
    end else if (en) begin
      m_pre = 1'b1;
    end
    m_step = evt;
    m_led = n_led;
    e.led = m_led;
    e.cnt = m_cnt;
    e.step = m_step;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    obs_t o, e;
    int i;
    enable = 1'b0;
    mode = 2'd0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    checks += 3;
    if (led_out !== 4'hF) begin
      failures++;
      $display("FAIL reset_led got=%h want=f", led_out);
    end
    if (count !== 8'h00) begin
      failures++;
      $display("FAIL reset_cnt got=%h want=00", count);
    end
    if (step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_step got=%b want=0", step_pulse);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    i = 0;
    while (m_cnt != 8'h37) begin
      cyc(1'b1, 2'd0);
      i++;
      e = exp_q.pop_front();
      o = {led_out, count, step_pulse};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_run cyc=%0d got=%h want=%h", i, o, e);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    checks += 3;
    if (led_out !== 4'hF) begin
      failures++;
      $display("FAIL midreset_led got=%h want=f", led_out);
    end
    if (count !== 8'h00) begin
      failures++;
      $display("FAIL midreset_cnt got=%h want=00", count);
    end
    if (step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL midreset_step got=%b want=0", step_pulse);
    end
  endtask

  task automatic test_binary();
    obs_t o, e;
    do_reset();
    n_pulse = 0;
    for (int i = 1; i <= 33; i++) begin
      cyc(1'b1, 2'd0);
      e = exp_q.pop_front();
      o = {led_out, count, step_pulse};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL binary cyc=%0d got=%h want=%h", i, o, e);
      end
      if (step_pulse === 1'b1) n_pulse++;
      if (i == 32) begin
        checks++;
        if (count !== 8'd16 || step_pulse !== 1'b1) begin
          failures++;
          $display("FAIL binary_c32 got cnt=%0d step=%b want cnt=16 step=1",
                   count, step_pulse);
        end
      end
      if (i == 33) begin
        checks++;
        if (led_out !== 4'hE) begin
          failures++;
          $display("FAIL binary_led got=%h want=e", led_out);
        end
      end
    end
    checks++;
    if (n_pulse != 1) begin
      failures++;
      $display("FAIL binary_pulses got=%0d want=1", n_pulse);
    end
  endtask

  task automatic test_wrap();
    obs_t o, e;
    for (int i = 34; i <= 513; i++) begin
      cyc(1'b1, 2'd0);
      e = exp_q.pop_front();
      o = {led_out, count, step_pulse};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap cyc=%0d got=%h want=%h", i, o, e);
      end
      if (step_pulse === 1'b1) begin
        n_pulse++;
        checks++;
        if (i % 32 != 0) begin
          failures++;
          $display("FAIL wrap_spacing got cyc=%0d want multiple of 32", i);
        end
      end
      if (i == 512) begin
        checks++;
        if (count !== 8'd0) begin
          failures++;
          $display("FAIL wrap_cnt got=%h want=00", count);
        end
      end
      if (i == 513) begin
        checks++;
        if (led_out !== 4'hF) begin
          failures++;
          $display("FAIL wrap_led got=%h want=f", led_out);
        end
      end
    end
    checks++;
    if (n_pulse != 16) begin
      failures++;
      $display("FAIL wrap_pulses got=%0d want=16", n_pulse);
    end
  endtask

  task automatic test_scan();
    obs_t o, e;
    logic [3:0] want;
    logic pend;
    int n;
    do_reset();
    led_q.delete();
    led_q.push_back(4'hE);
    led_q.push_back(4'hD);
    led_q.push_back(4'hB);
    led_q.push_back(4'h7);
    led_q.push_back(4'hB);
    led_q.push_back(4'hD);
    led_q.push_back(4'hE);
    cyc(1'b0, 2'd1);
    void'(exp_q.pop_front());
    pend = 1'b1;
    n = 0;
    while (led_q.size() > 0 && n < 400) begin
      cyc(1'b1, 2'd1);
      n++;
      e = exp_q.pop_front();
      o = {led_out, count, step_pulse};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL scan cyc=%0d got=%h want=%h", n, o, e);
      end
      if (pend) begin
        want = led_q.pop_front();
        pend = 1'b0;
        checks++;
        if (led_out !== want) begin
          failures++;
          $display("FAIL scan_seq cyc=%0d got=%h want=%h", n, led_out, want);
        end
      end
      if (step_pulse === 1'b1) pend = 1'b1;
    end
    checks++;
    if (led_q.size() != 0) begin
      failures++;
      $display("FAIL scan_timeout got left=%0d want left=0", led_q.size());
    end
  endtask

  task automatic test_mode_change();
    obs_t o, e;
    int i;
    do_reset();
    i = 0;
    while (m_cnt != 8'd5) begin
      cyc(1'b1, 2'd0);
      i++;
      e = exp_q.pop_front();
      o = {led_out, count, step_pulse};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mchg_pre cyc=%0d got=%h want=%h", i, o, e);
      end
    end
    while (!(m_cnt == 8'h30 && m_pre)) begin
      cyc(1'b1, 2'd1);
      i++;
      e = exp_q.pop_front();
      o = {led_out, count, step_pulse};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mchg cyc=%0d got=%h want=%h", i, o, e);
      end
      if (m_cnt == 8'd15 && m_pre) begin
        checks++;
        if (led_out !== 4'hF) begin
          failures++;
          $display("FAIL mchg_hold got=%h want=f", led_out);
        end
      end
    end
    checks++;
    if (led_out !== 4'hB) begin
      failures++;
      $display("FAIL mchg_scan got=%h want=b", led_out);
    end
  endtask

  task automatic test_disable();
    obs_t o, e;
    int i;
    do_reset();
    i = 0;
    while (m_cnt != 8'd40) begin
      cyc(1'b1, 2'd0);
      i++;
      e = exp_q.pop_front();
      o = {led_out, count, step_pulse};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL dis_pre cyc=%0d got=%h want=%h", i, o, e);
      end
    end
    for (int k = 0; k < 100; k++) begin
      cyc(1'b0, 2'd0);
      e = exp_q.pop_front();
      o = {led_out, count, step_pulse};
      checks++;
      if (o !== e || count !== 8'd40 || step_pulse !== 1'b0) begin
        failures++;
        $display("FAIL dis_hold k=%0d got=%h want=%h", k, o, e);
      end
    end
    cyc(1'b0, 2'd3);
    void'(exp_q.pop_front());
    cyc(1'b0, 2'd3);
    void'(exp_q.pop_front());
    checks++;
    if (led_out !== 4'h0) begin
      failures++;
      $display("FAIL dis_solid got=%h want=0", led_out);
    end
    cyc(1'b1, 2'd3);
    void'(exp_q.pop_front());
    cyc(1'b1, 2'd3);
    e = exp_q.pop_front();
    o = {led_out, count, step_pulse};
    checks += 2;
    if (count !== 8'd41) begin
      failures++;
      $display("FAIL dis_resume got=%0d want=41", count);
    end
    if (o !== e) begin
      failures++;
      $display("FAIL dis_resume_obs got=%h want=%h", o, e);
    end
  endtask

  task automatic test_breathe();
    obs_t o, e;
    int i;
    do_reset();
    cyc(1'b0, 2'd2);
    void'(exp_q.pop_front());
    i = 0;
    while (!(m_cnt == 8'hA5 && m_pre)) begin
      cyc(1'b1, 2'd2);
      i++;
      e = exp_q.pop_front();
      o = {led_out, count, step_pulse};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL breathe cyc=%0d got=%h want=%h", i, o, e);
      end
      if (m_cnt == 8'h44 && m_pre) begin
        checks++;
        if (led_out !== 4'h0) begin
          failures++;
          $display("FAIL breathe_44 got=%h want=0", led_out);
        end
      end
    end
    checks++;
    if (led_out !== 4'hF) begin
      failures++;
      $display("FAIL breathe_a5 got=%h want=f", led_out);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_binary();
    test_wrap();
    test_scan();
    test_mode_change();
    test_disable();
    test_breathe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
